// File: rtl/ifetch_if.sv
// Fetch-unit bus: branch redirect, instruction-memory request/response and
// decode-buffer handshake, seen from the fetch unit (master) and its environment (slave).
interface ifetch_if #(
    parameter int XLEN = 32
);
    logic            branch_v_i;
    logic [XLEN-1:0] pc_nxt_i;
    logic            imem_req_v_o;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_req_rdy_i;
    logic            imem_rsp_v_i;
    logic [31:0]     imem_rsp_data_i;
    logic            dec_v_o;
    logic [31:0]     dec_instr_o;
    logic [XLEN-1:0] dec_pc_o;
    logic            dec_misalign_o;
    logic            dec_rdy_i;

    modport master (
        input  branch_v_i, pc_nxt_i, imem_req_rdy_i, imem_rsp_v_i,
               imem_rsp_data_i, dec_rdy_i,
        output imem_req_v_o, imem_req_addr_o, dec_v_o, dec_instr_o,
               dec_pc_o, dec_misalign_o
    );

    modport slave (
        output branch_v_i, pc_nxt_i, imem_req_rdy_i, imem_rsp_v_i,
               imem_rsp_data_i, dec_rdy_i,
        input  imem_req_v_o, imem_req_addr_o, dec_v_o, dec_instr_o,
               dec_pc_o, dec_misalign_o
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory request, a single-entry decode
// buffer, branch redirect handling and misaligned-PC fault injection.
module ifetch #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input logic      clk,
    input logic      reset_n,
    ifetch_if.master bus
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            dec_v;
    logic [31:0]     dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic            dec_misalign;
    logic            buf_free;
    logic            req_v;

    assign buf_free = !dec_v || bus.dec_rdy_i;
    assign req_v    = reset_n && (state == S_REQ) && buf_free &&
                      (pc[1:0] == 2'b00) && !bus.branch_v_i;

    assign bus.imem_req_v_o    = req_v;
    assign bus.imem_req_addr_o = pc;
    assign bus.dec_v_o         = dec_v;
    assign bus.dec_instr_o     = dec_instr;
    assign bus.dec_pc_o        = dec_pc;
    assign bus.dec_misalign_o  = dec_misalign;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_REQ;
            pc           <= RESET_VECTOR;
            dec_v        <= 1'b0;
            dec_instr    <= '0;
            dec_pc       <= '0;
            dec_misalign <= 1'b0;
        end else if (bus.branch_v_i) begin
            pc    <= bus.pc_nxt_i;
            dec_v <= 1'b0;
            // A request still in flight must have its response swallowed in DROP
            if ((state == S_WAIT || state == S_DROP) && !bus.imem_rsp_v_i)
                state <= S_DROP;
            else
                state <= S_REQ;
        end else begin
            if (dec_v && bus.dec_rdy_i)
                dec_v <= 1'b0;
            case (state)
                S_REQ: begin
                    if (req_v && bus.imem_req_rdy_i) begin
                        state <= S_WAIT;
                    end else if (pc[1:0] != 2'b00 && buf_free) begin
                        dec_v        <= 1'b1;
                        dec_instr    <= NOP_INSTR;
                        dec_pc       <= pc;
                        dec_misalign <= 1'b1;
                        state        <= S_HALT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_v_i) begin
                        dec_v        <= 1'b1;
                        dec_instr    <= bus.imem_rsp_data_i;
                        dec_pc       <= pc;
                        dec_misalign <= 1'b0;
                        pc           <= pc + XLEN'(4);
                        state        <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (bus.imem_rsp_v_i)
                        state <= S_REQ;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch: stepwise stimulus with hand-computed
// expectations covering streaming, stall, redirects, misalignment and wrap-around.
module tb_ifetch;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    ifetch_if #(.XLEN(32)) bus ();

    ifetch #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic br, input logic [31:0] nxt,
                                 input logic rsp, input logic [31:0] data);
        bus.branch_v_i      = br;
        bus.pc_nxt_i        = nxt;
        bus.imem_rsp_v_i    = rsp;
        bus.imem_rsp_data_i = data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.branch_v_i      = 1'b0;
        bus.pc_nxt_i        = '0;
        bus.imem_req_rdy_i  = 1'b1;
        bus.imem_rsp_v_i    = 1'b0;
        bus.imem_rsp_data_i = '0;
        bus.dec_rdy_i       = 1'b1;
        step();
        step();
        checkOutput("rst_req_v", 32'(bus.imem_req_v_o), 32'd0);
        checkOutput("rst_dec_v", 32'(bus.dec_v_o), 32'd0);
        checkOutput("rst_instr", bus.dec_instr_o, 32'd0);
        checkOutput("rst_dec_pc", bus.dec_pc_o, 32'd0);
        checkOutput("rst_misalign", 32'(bus.dec_misalign_o), 32'd0);
        checkOutput("rst_addr", bus.imem_req_addr_o, 32'd0);

        reset_n = 1'b1;
        #1;
        checkOutput("first_req_v", 32'(bus.imem_req_v_o), 32'd1);
        checkOutput("first_addr", bus.imem_req_addr_o, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0050_0093);
        checkOutput("wait_req_v", 32'(bus.imem_req_v_o), 32'd0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("ld0_dec_v", 32'(bus.dec_v_o), 32'd1);
        checkOutput("ld0_dec_pc", bus.dec_pc_o, 32'h0);
        checkOutput("ld0_instr", bus.dec_instr_o, 32'h0050_0093);
        checkOutput("ld0_req_v", 32'(bus.imem_req_v_o), 32'd1);
        checkOutput("ld0_addr", bus.imem_req_addr_o, 32'h4);

        // Decode stalls with a full buffer
        bus.dec_rdy_i = 1'b0;
        #1;
        checkOutput("stall_req_v", 32'(bus.imem_req_v_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("stall_req_v_hold", 32'(bus.imem_req_v_o), 32'd0);
            checkOutput("stall_dec_v", 32'(bus.dec_v_o), 32'd1);
            checkOutput("stall_dec_pc", bus.dec_pc_o, 32'h0);
            checkOutput("stall_instr", bus.dec_instr_o, 32'h0050_0093);
        end
        bus.dec_rdy_i = 1'b1;
        #1;
        checkOutput("unstall_req_v", 32'(bus.imem_req_v_o), 32'd1);
        checkOutput("unstall_addr", bus.imem_req_addr_o, 32'h4);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00A0_0113);
        checkOutput("consumed_dec_v", 32'(bus.dec_v_o), 32'd0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("ld4_dec_pc", bus.dec_pc_o, 32'h4);
        checkOutput("ld4_instr", bus.dec_instr_o, 32'h00A0_0113);
        checkOutput("ld4_addr", bus.imem_req_addr_o, 32'h8);
        checkOutput("ld4_req_v", 32'(bus.imem_req_v_o), 32'd1);

        // Redirect while waiting, response arrives one cycle later
        step();
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("drop_req_v", 32'(bus.imem_req_v_o), 32'd0);
        checkOutput("drop_dec_v", 32'(bus.dec_v_o), 32'd0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("dropped_dec_v", 32'(bus.dec_v_o), 32'd0);
        checkOutput("redir_req_v", 32'(bus.imem_req_v_o), 32'd1);
        checkOutput("redir_addr", bus.imem_req_addr_o, 32'h100);

        // Redirect in the same cycle as the response
        step();
        applyStimulus(1'b1, 32'h180, 1'b1, 32'h1111_1111);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("same_dec_v", 32'(bus.dec_v_o), 32'd0);
        checkOutput("same_req_v", 32'(bus.imem_req_v_o), 32'd1);
        checkOutput("same_addr", bus.imem_req_addr_o, 32'h180);

        // Redirect to a misaligned target
        applyStimulus(1'b1, 32'h102, 1'b0, 32'h0);
        checkOutput("br_blocks_req", 32'(bus.imem_req_v_o), 32'd0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("mis_req_v", 32'(bus.imem_req_v_o), 32'd0);
        checkOutput("mis_addr", bus.imem_req_addr_o, 32'h102);
        step();
        checkOutput("halt_dec_v", 32'(bus.dec_v_o), 32'd1);
        checkOutput("halt_instr", bus.dec_instr_o, 32'h0000_0013);
        checkOutput("halt_dec_pc", bus.dec_pc_o, 32'h102);
        checkOutput("halt_misalign", 32'(bus.dec_misalign_o), 32'd1);
        checkOutput("halt_req_v", 32'(bus.imem_req_v_o), 32'd0);
        step();
        checkOutput("halt_consumed", 32'(bus.dec_v_o), 32'd0);
        checkOutput("halt_req_v2", 32'(bus.imem_req_v_o), 32'd0);
        step();
        checkOutput("halt_req_v3", 32'(bus.imem_req_v_o), 32'd0);
        applyStimulus(1'b1, 32'h200, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("unhalt_req_v", 32'(bus.imem_req_v_o), 32'd1);
        checkOutput("unhalt_addr", bus.imem_req_addr_o, 32'h200);

        // PC wrap-around at the top of the address space
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("top_addr", bus.imem_req_addr_o, 32'hFFFF_FFFC);
        checkOutput("top_req_v", 32'(bus.imem_req_v_o), 32'd1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h2222_2222);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("wrap_dec_pc", bus.dec_pc_o, 32'hFFFF_FFFC);
        checkOutput("wrap_instr", bus.dec_instr_o, 32'h2222_2222);
        checkOutput("wrap_misalign", 32'(bus.dec_misalign_o), 32'd0);
        checkOutput("wrap_addr", bus.imem_req_addr_o, 32'h0);

        // Reset in the middle of a transaction, then a stray response in REQ
        step();
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_dec_v", 32'(bus.dec_v_o), 32'd0);
        checkOutput("mid_rst_req_v", 32'(bus.imem_req_v_o), 32'd0);
        checkOutput("mid_rst_addr", bus.imem_req_addr_o, 32'h0);
        step();
        reset_n = 1'b1;
        bus.imem_req_rdy_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h3333_3333);
        checkOutput("post_rst_req_v", 32'(bus.imem_req_v_o), 32'd1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("stray_rsp_dec_v", 32'(bus.dec_v_o), 32'd0);
        checkOutput("stray_rsp_req_v", 32'(bus.imem_req_v_o), 32'd1);
        checkOutput("stray_rsp_addr", bus.imem_req_addr_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the first PC fetched after reset.
REQ-002 Parameter XLEN, default XLEN from package riscv (32), SHALL set the width of all address ports.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port branch_v_i, input, 1: redirect request, driven from the branch unit's branch_v_o.
REQ-006 Port pc_nxt_i, input, XLEN: redirect target, driven from the branch unit's pc_nxt_o.
REQ-007 Port imem_req_v_o, output, 1: instruction memory request valid.
REQ-008 Port imem_req_addr_o, output, XLEN: request address, always equal to the internal pc.
REQ-009 Port imem_req_rdy_i, input, 1: memory accepts the request.
REQ-010 Port imem_rsp_v_i, input, 1: response valid; the response cannot be back-pressured.
REQ-011 Port imem_rsp_data_i, input, 32: instruction word.
REQ-012 Port dec_v_o, output, 1: the decode buffer holds a valid instruction.
REQ-013 Port dec_instr_o, output, 32: the buffered instruction.
REQ-014 Port dec_pc_o, output, XLEN: PC of the buffered instruction.
REQ-015 Port dec_misalign_o, output, 1: the buffered entry is an instruction-address-misaligned fault.
REQ-016 Port dec_rdy_i, input, 1: decode consumes the buffer when dec_v_o=1 and dec_rdy_i=1.

Function
REQ-017 The FSM SHALL have four states: REQ, WAIT, DROP and HALT.
REQ-018 buf_free SHALL be defined as (dec_v_o=0) OR (dec_rdy_i=1).
REQ-019 In REQ, imem_req_v_o SHALL equal buf_free AND (pc[1:0]=0) AND NOT branch_v_i.
REQ-020 In WAIT, DROP and HALT, imem_req_v_o SHALL be 0.
REQ-021 In REQ, when imem_req_v_o=1 and imem_req_rdy_i=1, the FSM SHALL go to WAIT.
REQ-022 In REQ with pc[1:0]!=0 and buf_free=1, the FSM SHALL load the buffer with instr=32'h0000_0013, pc=pc and misalign=1, then go to HALT.
REQ-023 In WAIT, on imem_rsp_v_i=1, the FSM SHALL load the buffer with {imem_rsp_data_i, pc, misalign=0}, set dec_v_o=1, set pc to pc+4 (modulo 2^XLEN, carry discarded) and go to REQ.
REQ-024 HALT SHALL be left only by a redirect.
REQ-025 Redirect SHALL have priority over every other event in every state.
REQ-026 On redirect, pc SHALL be set to pc_nxt_i unmodified.
REQ-027 On redirect, dec_v_o SHALL be cleared, even when dec_rdy_i=1 in the same cycle.
REQ-028 Redirect next state SHALL be DROP if in WAIT without imem_rsp_v_i in the same cycle; otherwise it SHALL be REQ.
REQ-029 In DROP, the next imem_rsp_v_i SHALL be discarded without touching the buffer or pc, then the FSM SHALL go to REQ.
REQ-030 A redirect in DROP SHALL update pc and stay in DROP.
REQ-031 A redirect in the same cycle as a WAIT response SHALL discard that response.
REQ-032 At most one memory request SHALL be outstanding at any time.
REQ-033 The buffer SHALL never be overwritten while dec_v_o=1 and dec_rdy_i=0.
REQ-034 Consume without reload SHALL clear dec_v_o on the next edge.
REQ-035 The buffer outputs SHALL hold stable while dec_v_o=1 and dec_rdy_i=0.
REQ-036 Memory-to-decode latency SHALL be 1 cycle: the rsp_v edge loads the buffer.
REQ-037 Peak throughput SHALL be one instruction per 2 cycles with a 1-cycle memory.

Reset
REQ-038 While reset_n=0: pc=RESET_VECTOR, state=REQ, dec_v_o=0, dec_instr_o=0, dec_pc_o=0, dec_misalign_o=0 and imem_req_v_o=0.
REQ-039 Reset asserted mid-transaction SHALL abandon it.
REQ-040 After reset release, the first request SHALL be to RESET_VECTOR.
REQ-041 Any response arriving in REQ after reset SHALL be ignored.

Verification
REQ-042 Stimulus: reset release, memory always ready, 1-cycle response 32'h00500093. Required: requests to 0x0, 0x4, 0x8; dec_pc_o=0x0 with dec_instr_o=32'h00500093; one instruction every 2 cycles.
REQ-043 Stimulus: dec_rdy_i=0 for 5 cycles with the buffer full. Required: imem_req_v_o=0 and outputs stable; request to the next PC issued in the cycle dec_rdy_i rises.
REQ-044 Stimulus: branch_v_i=1 with pc_nxt_i=0x100 while in WAIT, response one cycle later. Required: response dropped, dec_v_o=0, next request address 0x100.
REQ-045 Stimulus: branch_v_i=1 in the same cycle as imem_rsp_v_i in WAIT. Required: buffer not loaded; next request to pc_nxt_i.
REQ-046 Stimulus: redirect to 0x102. Required: no memory request; buffer {0x13, 0x102, misalign=1}; stays in HALT until redirect to 0x200, then requests 0x200.
REQ-047 Stimulus: pc=0xFFFF_FFFC, response received. Required: next request address 0x0000_0000.
